rgb_fade_sequencer: RTL and testbench

//  Sits between the three encoder value registers and the three pwm instances in the mixer.

---
 rtl/rgb_fade_sequencer_if.sv | 36 +++
 rtl/rgb_fade_sequencer.sv | 164 ++++++++++++++++
 tb/tb_rgb_fade_sequencer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rgb_fade_sequencer_if.sv
// +--------------------------------------------------------------------------+
// | rgb_fade_sequencer_if : encoder/store inputs and PWM level outputs        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface rgb_fade_sequencer_if #(
  parameter int WIDTH     = 8,
  parameter int N_PRESETS = 4
);
  localparam int IDX_W = $clog2(N_PRESETS);

  logic             auto_mode;
  logic [WIDTH-1:0] enc0;
  logic [WIDTH-1:0] enc1;
  logic [WIDTH-1:0] enc2;
  logic             store;
  logic [IDX_W-1:0] store_idx;
  logic [WIDTH-1:0] level0;
  logic [WIDTH-1:0] level1;
  logic [WIDTH-1:0] level2;
  logic [IDX_W-1:0] preset_idx;
  logic             fading;

  modport master (
    output auto_mode, enc0, enc1, enc2, store, store_idx,
    input  level0, level1, level2, preset_idx, fading
  );

  modport slave (
    input  auto_mode, enc0, enc1, enc2, store, store_idx,
    output level0, level1, level2, preset_idx, fading
  );
endinterface

`default_nettype wire

// File: rtl/rgb_fade_sequencer.sv
// +--------------------------------------------------------------------------+
// | rgb_fade_sequencer : manual pass-through or preset fade/hold sequencing  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module rgb_fade_sequencer #(
  parameter int WIDTH      = 8,
  parameter int N_PRESETS  = 4,
  parameter int TICK_DIV   = 256,
  parameter int HOLD_TICKS = 64
) (
  input  wire logic          clk,
  input  wire logic          reset,
  rgb_fade_sequencer_if.slave bus
);

  localparam int IDX_W  = $clog2(N_PRESETS);
  localparam int TICK_W = $clog2(TICK_DIV);
  localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

  localparam logic [TICK_W-1:0] c_tick_last = TICK_W'(TICK_DIV - 1);
  localparam logic [HOLD_W-1:0] c_hold_last = HOLD_W'(HOLD_TICKS - 1);

  typedef enum logic [1:0] {
    ST_MANUAL = 2'd0,
    ST_LOAD   = 2'd1,
    ST_FADE   = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next_state;

  logic [3*WIDTH-1:0]  r_preset [N_PRESETS];
  logic [WIDTH-1:0]    r_level0;
  logic [WIDTH-1:0]    r_level1;
  logic [WIDTH-1:0]    r_level2;
  logic [WIDTH-1:0]    r_target0;
  logic [WIDTH-1:0]    r_target1;
  logic [WIDTH-1:0]    r_target2;
  logic [TICK_W-1:0]   r_tick_cnt;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic [IDX_W-1:0]    r_preset_idx;
  logic                r_fading;

  logic                w_tick;
  logic                w_at_target;
  logic                w_fade_step;
  logic                w_hold_tick;
  logic                w_hold_done;

  // One LSB toward the target; saturates naturally since equality stops motion.
  function automatic logic [WIDTH-1:0] f_step(input logic [WIDTH-1:0] cur,
                                              input logic [WIDTH-1:0] tgt);
    if (cur < tgt)      return cur + WIDTH'(1);
    else if (cur > tgt) return cur - WIDTH'(1);
    else                return cur;
  endfunction

  assign w_tick      = (r_tick_cnt == c_tick_last);
  assign w_at_target = (r_level0 == r_target0) && (r_level1 == r_target1) &&
                       (r_level2 == r_target2);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_MANUAL;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_fade_step  = 1'b0;
    w_hold_tick  = 1'b0;
    w_hold_done  = 1'b0;
    case (r_state)
      ST_MANUAL: begin
        if (bus.auto_mode) w_next_state = ST_LOAD;
      end
      ST_LOAD: begin
        w_next_state = bus.auto_mode ? ST_FADE : ST_MANUAL;
      end
      ST_FADE: begin
        if (!bus.auto_mode)  w_next_state = ST_MANUAL;
        else if (w_at_target) w_next_state = ST_HOLD;
        else                  w_fade_step  = w_tick;
      end
      ST_HOLD: begin
        if (!bus.auto_mode) begin
          w_next_state = ST_MANUAL;
        end else begin
          w_hold_tick = w_tick;
          w_hold_done = w_tick && (r_hold_cnt == c_hold_last);
          if (w_hold_done) w_next_state = ST_LOAD;
        end
      end
      default: w_next_state = ST_MANUAL;
    endcase
  end

  // Preset table: nonblocking write means a same-cycle LOAD sees the old entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_PRESETS; i++) r_preset[i] <= '0;
    end else if (bus.store) begin
      r_preset[bus.store_idx] <= {bus.enc0, bus.enc1, bus.enc2};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tick_cnt <= '0;
    end else if (r_state == ST_LOAD || w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + TICK_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_level0     <= '0;
      r_level1     <= '0;
      r_level2     <= '0;
      r_target0    <= '0;
      r_target1    <= '0;
      r_target2    <= '0;
      r_hold_cnt   <= '0;
      r_preset_idx <= '0;
      r_fading     <= 1'b0;
    end else begin
      r_fading <= (w_next_state == ST_FADE);
      if (r_state == ST_MANUAL) begin
        r_level0 <= bus.enc0;
        r_level1 <= bus.enc1;
        r_level2 <= bus.enc2;
      end
      if (r_state == ST_LOAD) begin
        {r_target0, r_target1, r_target2} <= r_preset[r_preset_idx];
      end
      if (w_fade_step) begin
        r_level0 <= f_step(r_level0, r_target0);
        r_level1 <= f_step(r_level1, r_target1);
        r_level2 <= f_step(r_level2, r_target2);
      end
      if (r_state == ST_FADE && w_next_state == ST_HOLD) begin
        r_hold_cnt <= '0;
      end else if (w_hold_done) begin
        r_hold_cnt   <= '0;
        r_preset_idx <= r_preset_idx + IDX_W'(1);
      end else if (w_hold_tick) begin
        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
      end
    end
  end

  assign bus.level0     = r_level0;
  assign bus.level1     = r_level1;
  assign bus.level2     = r_level2;
  assign bus.preset_idx = r_preset_idx;
  assign bus.fading     = r_fading;

endmodule

`default_nettype wire

// File: tb/tb_rgb_fade_sequencer.sv
// +--------------------------------------------------------------------------+
// | tb_rgb_fade_sequencer : randomized bench with fade-schedule model        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_rgb_fade_sequencer;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int TD = 4;
  localparam int H  = 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  rgb_fade_sequencer_if #(.WIDTH(W), .N_PRESETS(N)) bus ();

  rgb_fade_sequencer #(
    .WIDTH(W), .N_PRESETS(N), .TICK_DIV(TD), .HOLD_TICKS(H)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: preset table, current colour and index as seen at a LOAD boundary.
  int mp [N][3];
  int ml [3];
  int mi;

  task automatic chk_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic chk_lv(input string tag, input int e0, input int e1, input int e2);
    chk_eq({tag, "_r"}, int'(bus.level0), e0);
    chk_eq({tag, "_g"}, int'(bus.level1), e1);
    chk_eq({tag, "_b"}, int'(bus.level2), e2);
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
    bus.store = 1'b0;
  endtask

  // Colour after k fade ticks from l toward t.
  function automatic int mv(input int l, input int t, input int k);
    int d;
    d = t - l;
    if (d > 0)      return l + ((k < d) ? k : d);
    else if (d < 0) return l - ((k < -d) ? k : -d);
    return l;
  endfunction

  task automatic set_enc_rand(output int v[3]);
    for (int c = 0; c < 3; c++) v[c] = int'($urandom_range(0, 255));
    bus.enc0 = W'(v[0]);
    bus.enc1 = W'(v[1]);
    bus.enc2 = W'(v[2]);
  endtask

  // Entered right after the edge that put the DUT into LOAD; returns at the next LOAD.
  task automatic auto_step(input bit st_load, input bit st_hold);
    int t[3];
    int l[3];
    int nv[3];
    int d;
    d = 0;
    for (int c = 0; c < 3; c++) begin
      t[c] = mp[mi][c];
      l[c] = ml[c];
      if ((t[c] - l[c]) > d) d = t[c] - l[c];
      if ((l[c] - t[c]) > d) d = l[c] - t[c];
    end
    if (st_load) begin
      set_enc_rand(nv);
      bus.store_idx = mi[$clog2(N)-1:0];
      bus.store     = 1'b1;
    end
    step_clk();
    if (st_load) for (int c = 0; c < 3; c++) mp[mi][c] = nv[c];
    chk_eq("fade_entry", int'(bus.fading), 1);
    chk_lv("fade_start", l[0], l[1], l[2]);
    for (int k = 1; k <= d; k++) begin
      repeat (TD - 1) step_clk();
      chk_lv("pre_tick", mv(l[0], t[0], k - 1), mv(l[1], t[1], k - 1), mv(l[2], t[2], k - 1));
      step_clk();
      chk_lv("on_tick", mv(l[0], t[0], k), mv(l[1], t[1], k), mv(l[2], t[2], k));
    end
    step_clk();
    chk_eq("hold_entry", int'(bus.fading), 0);
    chk_lv("hold_lv", t[0], t[1], t[2]);
    if (st_hold) begin
      set_enc_rand(nv);
      bus.store_idx = mi[$clog2(N)-1:0];
      bus.store     = 1'b1;
      for (int c = 0; c < 3; c++) mp[mi][c] = nv[c];
    end
    repeat (H * TD - 2) step_clk();
    chk_eq("hold_idx", int'(bus.preset_idx), mi);
    chk_lv("hold_end", t[0], t[1], t[2]);
    step_clk();
    mi = (mi + 1) % N;
    chk_eq("idx_adv", int'(bus.preset_idx), mi);
    for (int c = 0; c < 3; c++) ml[c] = t[c];
  endtask

  task automatic store_preset(input int idx, input int r, input int g, input int b);
    bus.enc0      = W'(r);
    bus.enc1      = W'(g);
    bus.enc2      = W'(b);
    bus.store_idx = idx[$clog2(N)-1:0];
    bus.store     = 1'b1;
    step_clk();
    mp[idx][0] = r; mp[idx][1] = g; mp[idx][2] = b;
    ml[0] = r; ml[1] = g; ml[2] = b;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int v[3];
    int rr;
    bus.auto_mode = 1'b0;
    bus.enc0 = '0; bus.enc1 = '0; bus.enc2 = '0;
    bus.store = 1'b0; bus.store_idx = '0;
    for (int i = 0; i < N; i++) for (int c = 0; c < 3; c++) mp[i][c] = 0;
    mi = 0;
    for (int c = 0; c < 3; c++) ml[c] = 0;

    repeat (2) @(posedge clk);
    #1;
    chk_lv("rst", 0, 0, 0);
    chk_eq("rst_idx", int'(bus.preset_idx), 0);
    chk_eq("rst_fading", int'(bus.fading), 0);
    reset = 1'b1;

    // Manual pass-through, one clock of latency.
    bus.enc0 = 8'h12; bus.enc1 = 8'h34; bus.enc2 = 8'h56;
    chk_lv("man_before", 0, 0, 0);
    step_clk();
    chk_lv("man_direct", 'h12, 'h34, 'h56);
    bus.enc0 = 8'hFF;
    step_clk();
    chk_lv("man_ff", 'hFF, 'h34, 'h56);
    for (int i = 0; i < 5; i++) begin
      set_enc_rand(v);
      step_clk();
      chk_lv("man_rand", v[0], v[1], v[2]);
    end

    // Directed presets, then AUTO from black through a full wrap.
    store_preset(0, 'h10, 0, 0);
    store_preset(1, 0, 'h08, 0);
    store_preset(3, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 255)));
    bus.enc0 = '0; bus.enc1 = '0; bus.enc2 = '0;
    step_clk();
    for (int c = 0; c < 3; c++) ml[c] = 0;
    bus.auto_mode = 1'b1;
    step_clk();
    auto_step(1'b0, 1'b0);
    auto_step(1'b0, 1'b0);
    auto_step(1'b0, 1'b1);
    auto_step(1'b0, 1'b0);
    chk_eq("wrap_idx", int'(bus.preset_idx), 0);
    for (int i = 0; i < 6; i++) begin
      rr = int'($urandom_range(0, 3));
      auto_step(rr[0], rr[1]);
    end

    // Leave AUTO from LOAD, reload active slot with a far colour, then exit mid-fade.
    bus.auto_mode = 1'b0;
    step_clk();
    chk_eq("exit_load_fading", int'(bus.fading), 0);
    store_preset(mi, 'hFF, 'h80, 'h07);
    bus.enc0 = '0; bus.enc1 = '0; bus.enc2 = '0;
    step_clk();
    for (int c = 0; c < 3; c++) ml[c] = 0;
    bus.auto_mode = 1'b1;
    step_clk();
    step_clk();
    repeat (3 * TD) step_clk();
    chk_lv("part_fade", 3, 3, 3);
    chk_eq("part_fading", int'(bus.fading), 1);
    set_enc_rand(v);
    bus.auto_mode = 1'b0;
    step_clk();
    chk_eq("exit_fading", int'(bus.fading), 0);
    chk_lv("exit_frozen", 3, 3, 3);
    step_clk();
    chk_lv("exit_track", v[0], v[1], v[2]);
    chk_eq("exit_idx", int'(bus.preset_idx), mi);
    bus.auto_mode = 1'b1;
    step_clk();
    for (int c = 0; c < 3; c++) ml[c] = v[c];
    auto_step(1'b0, 1'b0);

    // Asynchronous reset in the middle of a fade.
    step_clk();
    repeat (2 * TD) step_clk();
    #2;
    reset = 1'b0;
    #1;
    chk_lv("arst", 0, 0, 0);
    chk_eq("arst_idx", int'(bus.preset_idx), 0);
    chk_eq("arst_fading", int'(bus.fading), 0);
    bus.auto_mode = 1'b0;
    @(posedge clk);
    #1;
    chk_lv("arst_held", 0, 0, 0);
    reset = 1'b1;
    for (int i = 0; i < N; i++) for (int c = 0; c < 3; c++) mp[i][c] = 0;
    mi = 0;
    set_enc_rand(v);
    step_clk();
    chk_lv("post_rst_track", v[0], v[1], v[2]);
    for (int c = 0; c < 3; c++) ml[c] = v[c];
    bus.auto_mode = 1'b1;
    step_clk();
    auto_step(1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
